// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 byte serializer for the SSD1306 OLED panel.
// Takes one byte plus a D/C flag per handshake and shifts it out MSB-first.
// Each byte is framed by chip-select, with one SCLK half-period of setup
// before the first edge and one of hold after the last edge.
// The SCLK half-period is CLK_DIV clk_in cycles (legal range 1..255).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | CS high, ready for a new byte
// ST_SETUP | CS low, MOSI holds bit 7, SCLK low before the first rise
// ST_HIGH  | SCLK high; the panel has sampled MOSI on the rising edge
// ST_LOW   | SCLK low; MOSI carries the next bit
// ST_HOLD  | SCLK low after the last bit, before CS is released

module ssd1306_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       command_start,
  input  logic [7:0] command_in,
  input  logic       dc_in,
  output logic       command_ready,
  output logic       byte_done,
  output logic       oled_csn,
  output logic       oled_dc,
  output logic       oled_sclk,
  output logic       oled_mosi
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // The divider counts down from CLK_DIV-1 to zero, so each phase lasts
  // exactly CLK_DIV cycles including the cycle on which it is entered.
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  logic [2:0] state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] div_cnt;
  logic       div_tc;

  // Terminal count of the half-period timer.
  assign div_tc = (div_cnt == 8'd0);

  // MOSI is taken straight from the shift register MSB, which is itself a
  // flop. The register is cleared when a byte ends, so MOSI idles low.
  assign oled_mosi = shift_reg[7];

  // Sequencing of the handshake, the half-period timer, and the SPI pins.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= ST_IDLE;
      shift_reg     <= 8'h00;
      bit_cnt       <= 3'd0;
      div_cnt       <= 8'h00;
      command_ready <= 1'b1;
      byte_done     <= 1'b0;
      oled_csn      <= 1'b1;
      oled_dc       <= 1'b0;
      oled_sclk     <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (command_start) begin
            shift_reg     <= command_in;
            oled_dc       <= dc_in;
            oled_csn      <= 1'b0;
            command_ready <= 1'b0;
            bit_cnt       <= 3'd0;
            div_cnt       <= DIV_LOAD;
            state         <= ST_SETUP;
          end
        end

        // SETUP and LOW both end by raising SCLK; only their entry differs.
        ST_SETUP, ST_LOW: begin
          if (div_tc) begin
            oled_sclk <= 1'b1;
            div_cnt   <= DIV_LOAD;
            state     <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        ST_HIGH: begin
          if (div_tc) begin
            oled_sclk <= 1'b0;
            div_cnt   <= DIV_LOAD;
            if (bit_cnt == 3'd7) begin
              // Last bit keeps MOSI unchanged through the hold phase.
              state <= ST_HOLD;
            end else begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              bit_cnt   <= bit_cnt + 3'd1;
              state     <= ST_LOW;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        ST_HOLD: begin
          if (div_tc) begin
            oled_csn      <= 1'b1;
            command_ready <= 1'b1;
            shift_reg     <= 8'h00;
            byte_done     <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        default: begin
          state         <= ST_IDLE;
          shift_reg     <= 8'h00;
          oled_csn      <= 1'b1;
          oled_sclk     <= 1'b0;
          command_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
